// File: rtl/arm_defs_pkg.sv
// Shared encodings for the ARM decode stage: ALU opcodes, barrel-shifter modes,
// operand mux selects, fixed register numbers, instruction bit positions and
// the decode-stage state type.
package arm_defs_pkg;

    // ALU opcodes use the ARM data-processing opcode numbering directly.
    typedef enum logic [3:0] {
        AND = 4'h0, EOR = 4'h1, SUB = 4'h2, RSB = 4'h3,
        ADD = 4'h4, ADC = 4'h5, SBC = 4'h6, RSC = 4'h7,
        TST = 4'h8, TEQ = 4'h9, CMP = 4'hA, CMN = 4'hB,
        ORR = 4'hC, MOV = 4'hD, BIC = 4'hE, MVN = 4'hF
    } alu_op_t;

    // Barrel modes are {0, shift type, by-register}.
    typedef enum logic [3:0] {
        LSLIMM = 4'd0, LSLREG = 4'd1, LSRIMM = 4'd2, LSRREG = 4'd3,
        ASRIMM = 4'd4, ASRREG = 4'd5, RORIMM = 4'd6, RORREG = 4'd7
    } barrel_t;

    // What is fed into the shifter; code 0 means "no shifter operand".
    typedef enum logic [1:0] {
        SHIFTEE_NONE = 2'd0, IMMED_8_SEL = 2'd1, IMMED_32_SEL = 2'd2, RM_SEL = 2'd3
    } shiftee_sel_t;

    // Where the shift amount comes from; code 0 means "no shift".
    typedef enum logic [1:0] {
        SHIFTER_NONE = 2'd0, ROTATE_IMM_SEL = 2'd1, SHIFT_IMM_SEL = 2'd2, RS_SEL = 2'd3
    } shifter_sel_t;

    localparam int LINK_REG = 14;
    localparam int PC_REG   = 15;

    // S and L share bit 20; branch link flag shares bit 24 with P.
    localparam int I_BIT  = 25;
    localparam int P_BIT  = 24;
    localparam int BL_BIT = 24;
    localparam int U_BIT  = 23;
    localparam int W_BIT  = 21;
    localparam int S_BIT  = 20;
    localparam int L_BIT  = 20;

    typedef enum logic {
        IDLE  = 1'b0,
        MULTI = 1'b1
    } dec_state_t;

    // Map an ARM shift type and the by-register flag onto a barrel mode.
    function automatic logic [3:0] barrel_code(input logic [1:0] shift_type, input logic by_reg);
        return {1'b0, shift_type, by_reg};
    endfunction

endpackage

// File: rtl/arm_reglist_pick.sv
// Register-list helper for LDM/STM expansion: finds the lowest listed
// register, counts the listed registers, and strips the lowest one.
module arm_reglist_pick #(
    parameter int NREG   = 16,
    parameter int RIDX_W = $clog2(NREG),
    parameter int CNT_W  = $clog2(NREG + 1)
) (
    input  logic [NREG-1:0]   mask_i,
    output logic [RIDX_W-1:0] low_idx_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [NREG-1:0]   rest_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        low_idx_o = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask_i[i]) low_idx_o = RIDX_W'(i);
        end
    end

    // Population count of the register list.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < NREG; i++) begin
            count_o = count_o + CNT_W'(mask_i[i]);
        end
    end

    assign rest_o = mask_i & (mask_i - NREG'(1));

endmodule

// File: rtl/arm_decode_stage.sv
// Registered, handshaked ARM decode stage. Accepts one instruction per cycle,
// drops condition-failed instructions, and emits one registered uop per cycle.
// LDM/STM are expanded into one uop per listed register, lowest first.
module arm_decode_stage
    import arm_defs_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  NREG   = 16,
    localparam int RIDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              inst_valid,
    input  logic [DATA_W-1:0] inst,
    input  logic              cond_pass,
    output logic              inst_ready,
    output logic              uop_valid,
    input  logic              uop_ready,
    output logic [RIDX_W-1:0] read_rn,
    output logic [RIDX_W-1:0] read_rm,
    output logic [RIDX_W-1:0] read_rs,
    output logic [RIDX_W-1:0] write_rd,
    output logic              rd_we,
    output logic              cpsr_we,
    output logic              pc_we,
    output logic              rn_we,
    output logic              mem_re,
    output logic              mem_we,
    output logic [3:0]        alu_sel,
    output logic [3:0]        barrel_sel,
    output logic [1:0]        shiftee_sel,
    output logic [1:0]        shifter_sel,
    output logic [DATA_W-1:0] imm,
    output logic [3:0]        rotate_imm,
    output logic [4:0]        shift_imm,
    output logic [DATA_W-1:0] wb_off,
    output logic              link
);

    localparam int CNT_W = $clog2(NREG + 1);

    typedef struct packed {
        logic [RIDX_W-1:0] read_rn;
        logic [RIDX_W-1:0] read_rm;
        logic [RIDX_W-1:0] read_rs;
        logic [RIDX_W-1:0] write_rd;
        logic              rd_we;
        logic              cpsr_we;
        logic              pc_we;
        logic              rn_we;
        logic              mem_re;
        logic              mem_we;
        logic [3:0]        alu_sel;
        logic [3:0]        barrel_sel;
        logic [1:0]        shiftee_sel;
        logic [1:0]        shifter_sel;
        logic [DATA_W-1:0] imm;
        logic [3:0]        rotate_imm;
        logic [4:0]        shift_imm;
        logic [DATA_W-1:0] wb_off;
        logic              link;
    } uop_t;

    // One transfer of an LDM/STM: address = Rn + offset; the last transfer
    // carries the base writeback delta.
    function automatic uop_t ldm_uop(
        input logic [RIDX_W-1:0] reg_idx,
        input logic [DATA_W-1:0] offset,
        input logic              last,
        input logic [RIDX_W-1:0] base,
        input logic              load,
        input logic              wback,
        input logic              up,
        input logic [CNT_W-1:0]  count
    );
        uop_t              u;
        logic [DATA_W-1:0] span;
        u             = '0;
        span          = DATA_W'(count) << 2;
        u.read_rn     = base;
        u.alu_sel     = ADD;
        u.shiftee_sel = IMMED_32_SEL;
        u.imm         = offset;
        u.mem_re      = load;
        u.mem_we      = !load;
        if (load) begin
            u.write_rd = reg_idx;
            u.rd_we    = 1'b1;
            u.pc_we    = (reg_idx == RIDX_W'(PC_REG));
        end else begin
            u.read_rm  = reg_idx;
        end
        if (last) begin
            u.rn_we  = wback;
            u.wb_off = up ? span : ('0 - span);
        end
        return u;
    endfunction

    dec_state_t        state_q, state_d;
    logic              uop_valid_q, uop_valid_d;
    uop_t              uop_q, uop_d;
    logic [NREG-1:0]   rem_q, rem_d;
    logic [RIDX_W-1:0] base_q, base_d;
    logic              load_q, load_d;
    logic              wback_q, wback_d;
    logic              up_q, up_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [RIDX_W-1:0] new_idx, rem_idx;
    logic [CNT_W-1:0]  new_cnt, rem_cnt;
    logic [NREG-1:0]   new_rest, rem_rest;
    logic [DATA_W-1:0] new_span, ldm_start;
    uop_t              dec_uop;
    logic              dec_is_ldm;
    logic              accept, advance;

    // The condition field is resolved by the upstream condition checker.
    logic unused_cond;
    assign unused_cond = ^inst[DATA_W-1:28];

    arm_reglist_pick #(.NREG(NREG)) u_pick_new (
        .mask_i    (inst[NREG-1:0]),
        .low_idx_o (new_idx),
        .count_o   (new_cnt),
        .rest_o    (new_rest)
    );

    arm_reglist_pick #(.NREG(NREG)) u_pick_rem (
        .mask_i    (rem_q),
        .low_idx_o (rem_idx),
        .count_o   (rem_cnt),
        .rest_o    (rem_rest)
    );

    assign inst_ready = (state_q == IDLE) && (!uop_valid_q || uop_ready);
    assign accept     = inst_valid && inst_ready;
    assign advance    = uop_valid_q && uop_ready;

    // First LDM/STM offset: IA 0, IB +4, DA 4-4n, DB -4n.
    assign new_span = DATA_W'(new_cnt) << 2;
    always_comb begin
        if (inst[P_BIT]) ldm_start = inst[U_BIT] ? DATA_W'(4) : ('0 - new_span);
        else             ldm_start = inst[U_BIT] ? '0 : (DATA_W'(4) - new_span);
    end

    // Decode the instruction offered by fetch into its (first) uop.
    always_comb begin
        dec_uop    = '0;
        dec_is_ldm = 1'b0;
        if (inst[27:26] == 2'b00) begin
            // bit7 & bit4 set with I=0 is multiply/extra load-store space.
            if (inst[I_BIT] || !inst[4] || !inst[7]) begin
                dec_uop.alu_sel  = inst[24:21];
                dec_uop.cpsr_we  = inst[S_BIT];
                dec_uop.rd_we    = (inst[24:23] != 2'b10);
                dec_uop.read_rn  = inst[16 +: RIDX_W];
                dec_uop.write_rd = inst[12 +: RIDX_W];
                dec_uop.pc_we    = dec_uop.rd_we && (inst[12 +: RIDX_W] == RIDX_W'(PC_REG));
                if (inst[I_BIT]) begin
                    dec_uop.shiftee_sel = IMMED_8_SEL;
                    dec_uop.shifter_sel = ROTATE_IMM_SEL;
                    dec_uop.barrel_sel  = RORIMM;
                    dec_uop.imm         = DATA_W'(inst[7:0]);
                    dec_uop.rotate_imm  = inst[11:8];
                end else begin
                    dec_uop.read_rm     = inst[0 +: RIDX_W];
                    dec_uop.shiftee_sel = RM_SEL;
                    dec_uop.barrel_sel  = barrel_code(inst[6:5], inst[4]);
                    if (!inst[4]) begin
                        dec_uop.shifter_sel = SHIFT_IMM_SEL;
                        dec_uop.shift_imm   = inst[11:7];
                    end else begin
                        dec_uop.shifter_sel = RS_SEL;
                        dec_uop.read_rs     = inst[8 +: RIDX_W];
                    end
                end
            end
        end else if (inst[27:26] == 2'b01) begin
            dec_uop.mem_re   = inst[L_BIT];
            dec_uop.mem_we   = !inst[L_BIT];
            dec_uop.alu_sel  = inst[U_BIT] ? ADD : SUB;
            dec_uop.read_rn  = inst[16 +: RIDX_W];
            dec_uop.write_rd = inst[12 +: RIDX_W];
            dec_uop.rd_we    = inst[L_BIT];
            dec_uop.rn_we    = inst[W_BIT] || !inst[P_BIT];
            // Store data travels on the Rs read port since Rm may hold the offset.
            if (!inst[L_BIT]) dec_uop.read_rs = inst[12 +: RIDX_W];
            if (!inst[I_BIT]) begin
                dec_uop.shiftee_sel = IMMED_32_SEL;
                dec_uop.imm         = DATA_W'(inst[11:0]);
            end else begin
                dec_uop.read_rm     = inst[0 +: RIDX_W];
                dec_uop.shiftee_sel = RM_SEL;
                dec_uop.shifter_sel = SHIFT_IMM_SEL;
                dec_uop.shift_imm   = inst[11:7];
                dec_uop.barrel_sel  = barrel_code(inst[6:5], 1'b0);
            end
        end else if (inst[27:25] == 3'b101) begin
            dec_uop.imm         = {{(DATA_W-26){inst[23]}}, inst[23:0], 2'b00};
            dec_uop.read_rn     = RIDX_W'(PC_REG);
            dec_uop.alu_sel     = ADD;
            dec_uop.shiftee_sel = IMMED_32_SEL;
            dec_uop.pc_we       = 1'b1;
            if (inst[BL_BIT]) begin
                dec_uop.link     = 1'b1;
                dec_uop.write_rd = RIDX_W'(LINK_REG);
                dec_uop.rd_we    = 1'b1;
            end
        end else if (inst[27:25] == 3'b100) begin
            dec_is_ldm = 1'b1;
            dec_uop    = ldm_uop(new_idx, ldm_start, new_cnt == CNT_W'(1),
                                 inst[16 +: RIDX_W], inst[L_BIT], inst[W_BIT],
                                 inst[U_BIT], new_cnt);
        end
    end

    // Next-state: flush first, then expansion, then new accepts / drains.
    // The final LDM/STM uop is loaded in IDLE so the next instruction can be
    // accepted in the same cycle that uop leaves.
    always_comb begin
        state_d     = state_q;
        uop_valid_d = uop_valid_q;
        uop_d       = uop_q;
        rem_d       = rem_q;
        base_d      = base_q;
        load_d      = load_q;
        wback_d     = wback_q;
        up_d        = up_q;
        cnt_d       = cnt_q;
        if (flush) begin
            state_d     = IDLE;
            uop_valid_d = 1'b0;
        end else if (state_q == MULTI) begin
            if (advance) begin
                uop_d = ldm_uop(rem_idx, uop_q.imm + DATA_W'(4), rem_cnt == CNT_W'(1),
                                base_q, load_q, wback_q, up_q, cnt_q);
                rem_d = rem_rest;
                if (rem_cnt == CNT_W'(1)) state_d = IDLE;
            end
        end else if (accept) begin
            uop_valid_d = cond_pass && !(dec_is_ldm && new_cnt == '0);
            if (cond_pass) begin
                uop_d = dec_uop;
                if (dec_is_ldm && new_cnt > CNT_W'(1)) begin
                    state_d = MULTI;
                    rem_d   = new_rest;
                    base_d  = inst[16 +: RIDX_W];
                    load_d  = inst[L_BIT];
                    wback_d = inst[W_BIT];
                    up_d    = inst[U_BIT];
                    cnt_d   = new_cnt;
                end
            end
        end else if (advance) begin
            uop_valid_d = 1'b0;
        end
    end

    // State and registered uop outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            uop_valid_q <= 1'b0;
            uop_q       <= '0;
            rem_q       <= '0;
            base_q      <= '0;
            load_q      <= 1'b0;
            wback_q     <= 1'b0;
            up_q        <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            uop_valid_q <= uop_valid_d;
            uop_q       <= uop_d;
            rem_q       <= rem_d;
            base_q      <= base_d;
            load_q      <= load_d;
            wback_q     <= wback_d;
            up_q        <= up_d;
            cnt_q       <= cnt_d;
        end
    end

    assign uop_valid   = uop_valid_q;
    assign read_rn     = uop_q.read_rn;
    assign read_rm     = uop_q.read_rm;
    assign read_rs     = uop_q.read_rs;
    assign write_rd    = uop_q.write_rd;
    assign rd_we       = uop_q.rd_we;
    assign cpsr_we     = uop_q.cpsr_we;
    assign pc_we       = uop_q.pc_we;
    assign rn_we       = uop_q.rn_we;
    assign mem_re      = uop_q.mem_re;
    assign mem_we      = uop_q.mem_we;
    assign alu_sel     = uop_q.alu_sel;
    assign barrel_sel  = uop_q.barrel_sel;
    assign shiftee_sel = uop_q.shiftee_sel;
    assign shifter_sel = uop_q.shifter_sel;
    assign imm         = uop_q.imm;
    assign rotate_imm  = uop_q.rotate_imm;
    assign shift_imm   = uop_q.shift_imm;
    assign wb_off      = uop_q.wb_off;
    assign link        = uop_q.link;

endmodule

// File: tb/tb_arm_decode_stage.sv
// Directed bench for arm_decode_stage: data processing, load/store, branch,
// LDM/STM expansion with stall, flush and reset, and dropped instructions.
module tb_arm_decode_stage;
    import arm_defs_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = '0;
    logic        cond_pass = 1'b0;
    logic        uop_ready = 1'b0;
    logic        inst_ready, uop_valid;
    logic [3:0]  read_rn, read_rm, read_rs, write_rd;
    logic        rd_we, cpsr_we, pc_we, rn_we, mem_re, mem_we, link;
    logic [3:0]  alu_sel, barrel_sel, rotate_imm;
    logic [1:0]  shiftee_sel, shifter_sel;
    logic [31:0] imm, wb_off;
    logic [4:0]  shift_imm;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arm_decode_stage #(.DATA_W(32), .NREG(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .inst_valid(inst_valid), .inst(inst), .cond_pass(cond_pass),
        .inst_ready(inst_ready), .uop_valid(uop_valid), .uop_ready(uop_ready),
        .read_rn(read_rn), .read_rm(read_rm), .read_rs(read_rs), .write_rd(write_rd),
        .rd_we(rd_we), .cpsr_we(cpsr_we), .pc_we(pc_we), .rn_we(rn_we),
        .mem_re(mem_re), .mem_we(mem_we), .alu_sel(alu_sel), .barrel_sel(barrel_sel),
        .shiftee_sel(shiftee_sel), .shifter_sel(shifter_sel), .imm(imm),
        .rotate_imm(rotate_imm), .shift_imm(shift_imm), .wb_off(wb_off), .link(link)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction for a single edge, then withdraw it.
    task automatic issue(input logic [31:0] w, input logic c);
        inst_valid = 1'b1;
        inst       = w;
        cond_pass  = c;
        tick();
        inst_valid = 1'b0;
        cond_pass  = 1'b0;
        $display("issue inst=%08h cond_pass=%0b -> uop_valid=%0b", w, c, uop_valid);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst uop_valid", uop_valid, 0);
        chk("rst write_rd", write_rd, 0);
        chk("rst imm", imm, 0);
        chk("rst alu_sel", alu_sel, 0);
        chk("rst rd_we", rd_we, 0);
        chk("rst shiftee_sel", shiftee_sel, 0);
        rst_n = 1'b1;
        #1;
        chk("rst inst_ready", inst_ready, 1);
        uop_ready = 1'b1;

        // ADD r1,r2,#5
        issue(32'hE2821005, 1'b1);
        chk("add uop_valid", uop_valid, 1);
        chk("add alu_sel", alu_sel, 4);
        chk("add read_rn", read_rn, 2);
        chk("add write_rd", write_rd, 1);
        chk("add rd_we", rd_we, 1);
        chk("add imm", imm, 5);
        chk("add shiftee_sel", shiftee_sel, IMMED_8_SEL);
        chk("add pc_we", pc_we, 0);

        // CMP r3,r4
        issue(32'hE1530004, 1'b1);
        chk("cmp alu_sel", alu_sel, 32'hA);
        chk("cmp rd_we", rd_we, 0);
        chk("cmp cpsr_we", cpsr_we, 1);
        chk("cmp read_rm", read_rm, 4);
        chk("cmp read_rn", read_rn, 3);
        chk("cmp barrel_sel", barrel_sel, LSLIMM);
        chk("cmp shifter_sel", shifter_sel, SHIFT_IMM_SEL);

        // Condition-failed ADD: consumed, previous uop drains, nothing new
        issue(32'hE2821005, 1'b0);
        chk("condfail uop_valid", uop_valid, 0);
        chk("condfail inst_ready", inst_ready, 1);

        // ADD r0,r1,r2,ASR r3
        issue(32'hE0810352, 1'b1);
        chk("regsh barrel_sel", barrel_sel, ASRREG);
        chk("regsh read_rs", read_rs, 3);
        chk("regsh read_rm", read_rm, 2);
        chk("regsh shifter_sel", shifter_sel, RS_SEL);

        // MOV pc,lr
        issue(32'hE1A0F00E, 1'b1);
        chk("movpc pc_we", pc_we, 1);
        chk("movpc rd_we", rd_we, 1);
        chk("movpc alu_sel", alu_sel, MOV);
        chk("movpc read_rm", read_rm, 14);

        // LDR r2,[r1,#8]
        issue(32'hE5912008, 1'b1);
        chk("ldr mem_re", mem_re, 1);
        chk("ldr mem_we", mem_we, 0);
        chk("ldr alu_sel", alu_sel, ADD);
        chk("ldr imm", imm, 8);
        chk("ldr rn_we", rn_we, 0);
        chk("ldr write_rd", write_rd, 2);

        // STR r2,[r1],#-4 (post-indexed writes back)
        issue(32'hE4012004, 1'b1);
        chk("str mem_we", mem_we, 1);
        chk("str mem_re", mem_re, 0);
        chk("str alu_sel", alu_sel, SUB);
        chk("str rn_we", rn_we, 1);
        chk("str imm", imm, 4);
        chk("str rd_we", rd_we, 0);

        // BL +0x40
        issue(32'hEB000010, 1'b1);
        chk("bl imm", imm, 32'h40);
        chk("bl read_rn", read_rn, 15);
        chk("bl pc_we", pc_we, 1);
        chk("bl link", link, 1);
        chk("bl write_rd", write_rd, 14);
        chk("bl rd_we", rd_we, 1);

        // B . (negative offset)
        issue(32'hEAFFFFFE, 1'b1);
        chk("b imm", imm, 32'hFFFF_FFF8);
        chk("b link", link, 0);
        chk("b rd_we", rd_we, 0);
        tick();
        chk("drain uop_valid", uop_valid, 0);

        // LDMIA r0!,{r1,r3,r7} at full throughput
        issue(32'hE8B0008A, 1'b1);
        chk("ldm0 write_rd", write_rd, 1);
        chk("ldm0 imm", imm, 0);
        chk("ldm0 rn_we", rn_we, 0);
        chk("ldm0 mem_re", mem_re, 1);
        chk("ldm0 inst_ready", inst_ready, 0);
        tick();
        chk("ldm1 write_rd", write_rd, 3);
        chk("ldm1 imm", imm, 4);
        chk("ldm1 rn_we", rn_we, 0);
        chk("ldm1 inst_ready", inst_ready, 0);
        tick();
        chk("ldm2 write_rd", write_rd, 7);
        chk("ldm2 imm", imm, 8);
        chk("ldm2 rn_we", rn_we, 1);
        chk("ldm2 wb_off", wb_off, 12);
        chk("ldm2 inst_ready", inst_ready, 1);
        tick();
        chk("ldm end uop_valid", uop_valid, 0);

        // Same LDM, execute stalls on the second uop
        issue(32'hE8B0008A, 1'b1);
        tick();
        chk("stall pre write_rd", write_rd, 3);
        uop_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall write_rd", write_rd, 3);
            chk("stall imm", imm, 4);
            chk("stall uop_valid", uop_valid, 1);
            chk("stall inst_ready", inst_ready, 0);
        end
        uop_ready = 1'b1;
        tick();
        chk("stall post write_rd", write_rd, 7);
        chk("stall post wb_off", wb_off, 12);
        tick();
        chk("stall end uop_valid", uop_valid, 0);

        // Same LDM, flushed while the second uop is stalled
        issue(32'hE8B0008A, 1'b1);
        tick();
        uop_ready = 1'b0;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        uop_ready = 1'b1;
        chk("flush uop_valid", uop_valid, 0);
        chk("flush inst_ready", inst_ready, 1);
        tick();
        chk("flush no resume", uop_valid, 0);

        // Flush beats a same-cycle accept
        inst_valid = 1'b1;
        inst       = 32'hE2821005;
        cond_pass  = 1'b1;
        flush      = 1'b1;
        tick();
        inst_valid = 1'b0;
        cond_pass  = 1'b0;
        flush      = 1'b0;
        chk("flush vs accept uop_valid", uop_valid, 0);

        // Empty register list: consumed with no uop
        issue(32'hE2821005, 1'b1);
        chk("pre-empty uop_valid", uop_valid, 1);
        issue(32'hE8B00000, 1'b1);
        chk("empty ldm uop_valid", uop_valid, 0);
        chk("empty ldm inst_ready", inst_ready, 1);

        // STMDB sp!,{r4,lr}
        issue(32'hE92D4010, 1'b1);
        chk("stmdb0 read_rm", read_rm, 4);
        chk("stmdb0 imm", imm, 32'hFFFF_FFF8);
        chk("stmdb0 mem_we", mem_we, 1);
        chk("stmdb0 rn_we", rn_we, 0);
        chk("stmdb0 inst_ready", inst_ready, 0);
        tick();
        chk("stmdb1 read_rm", read_rm, 14);
        chk("stmdb1 imm", imm, 32'hFFFF_FFFC);
        chk("stmdb1 rn_we", rn_we, 1);
        chk("stmdb1 wb_off", wb_off, 32'hFFFF_FFF8);
        tick();
        chk("stmdb end uop_valid", uop_valid, 0);

        // Reset in the middle of an LDM
        issue(32'hE8B0008A, 1'b1);
        chk("rstmid pre write_rd", write_rd, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid uop_valid", uop_valid, 0);
        chk("rstmid write_rd", write_rd, 0);
        chk("rstmid imm", imm, 0);
        chk("rstmid mem_re", mem_re, 0);
        chk("rstmid inst_ready", inst_ready, 1);
        rst_n = 1'b1;
        tick();
        chk("rstmid no resume", uop_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arm_decode_stage.md
# arm_decode_stage

Registered, handshaked ARM decode stage replacing the purely combinational decoder in the core's decode slot. It accepts one 32-bit instruction per cycle from fetch, gates on the condition check, and emits one micro-op (uop) per cycle to register-read/execute. It adds what the combinational decoder lacks: valid/ready backpressure, flush, compare-op write suppression, single load/store decode, and sequential expansion of LDM/STM into one uop per listed register.

## Interface
- `DATA_W`, default 32: instruction and immediate width.
- `NREG`, default 16: architectural register count; `RIDX_W = $clog2(NREG)`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous pipeline flush.
- `inst_valid`  in  1  fetch holds a valid instruction.
- `inst`  in  DATA_W  instruction word.
- `cond_pass`  in  1  condition-checker result for `inst`.
- `inst_ready`  out  1  stage accepts `inst` this cycle.
- `uop_valid`  out  1  uop fields valid.
- `uop_ready`  in  1  execute accepts the uop.
- `read_rn`, `read_rm`, `read_rs`, `write_rd`  out  RIDX_W  register indices.
- `rd_we`, `cpsr_we`, `pc_we`, `rn_we`  out  1  write enables (`rn_we` is base writeback).
- `mem_re`, `mem_we`  out  1  memory read/write.
- `alu_sel`, `barrel_sel`  out  4  ALU op and barrel-shifter mode.
- `shiftee_sel`, `shifter_sel`  out  2  mux selects.
- `imm`  out  DATA_W  immediate: imm8, imm12, sign-extended branch offset, or LDM/STM offset.
- `rotate_imm`  out  4; `shift_imm`  out  5.
- `wb_off`  out  DATA_W  signed base writeback delta for LDM/STM.
- `link`  out  1  branch with link.

## Operation
- States are IDLE and MULTI.
- In IDLE, `inst_ready = !uop_valid || uop_ready`. In MULTI, `inst_ready = 0`.
- Handshake: a transfer occurs when `inst_valid && inst_ready`. If `cond_pass = 0`, the instruction is consumed and no uop is produced.
- Data processing (`[27:26]=00`):
  - `alu_sel = inst[24:21]`; `cpsr_we = S`.
  - `rd_we = 0` for opcodes 10xx (TST/TEQ/CMP/CMN); otherwise `rd_we = 1`.
  - If `Rd = 15` and `rd_we = 1`, also set `pc_we = 1`.
  - Shifter operand encoding follows the existing decoder: I=1 gives imm8/rotate; I=0 with bit4=0 is an immediate shift; I=0 with bit4=1 and bit7=0 is a register shift via `read_rs`.
- Single load/store (`[27:26]=01`):
  - `mem_re = L`, `mem_we = !L`.
  - `alu_sel = ADD` if U=1, otherwise `SUB`.
  - I=0 selects `imm = inst[11:0]`; I=1 selects a shifted Rm.
  - `rn_we = W || !P`.
- Branch (`[27:25]=101`):
  - `imm = sext(inst[23:0]) << 2`; `read_rn = 15`; `alu_sel = ADD`; `pc_we = 1`.
  - If L=1, also `link = 1`, `write_rd = 14`, `rd_we = 1`.
- LDM/STM (`[27:25]=100`):
  - Let `n = popcount(inst[15:0])`. If `n = 0`, the instruction is consumed with no uop.
  - Otherwise emit `n` uops, lowest register first, with `write_rd` (or `read_rm` for STM) set to that register.
  - `imm = start + 4*k`, where `start` is 0 for IA, 4 for IB, `-4n+4` for DA, and `-4n` for DB.
  - The last uop carries `rn_we = W` and `wb_off = +4n` (U=1) or `-4n` (U=0).
  - If `n > 1`, enter MULTI holding the remaining mask; return to IDLE when the last uop transfers.
- Any other encoding produces a uop with all enables 0.
- Flush: the next cycle has `uop_valid = 0` and state IDLE, aborting any expansion. Flush wins over a same-cycle accept.

## Timing
- Reset values: `uop_valid = 0`, state IDLE, all uop fields and enables 0. `inst_ready = 1` immediately after reset.
- Latency: one cycle from accept to `uop_valid`.
- Throughput: one uop per cycle; an LDM/STM of `n` registers occupies `n` cycles at full throughput.
- While `uop_valid && !uop_ready`, every uop field holds stable and the expansion does not advance.
- `inst_ready` is combinational from state, `uop_valid`, and `uop_ready`; no output depends combinationally on `inst`.
- Reset asserted mid-expansion returns the block to IDLE asynchronously.

## Structure
- Package `arm_defs_pkg`:
  - ALU opcodes (`ADD`, `SUB`, ...) and barrel codes (`LSLIMM` ... `RORREG`).
  - Mux select codes (`IMMED_8_SEL`, `IMMED_32_SEL`, `RM_SEL`, `ROTATE_IMM_SEL`, `SHIFT_IMM_SEL`, `RS_SEL`).
  - Register constants `LINK_REG = 14`, `PC_REG = 15`.
  - Bit positions `I_BIT`, `S_BIT`, `P_BIT`, `U_BIT`, `W_BIT`, `L_BIT`.
  - State enum.
- Sub-module `arm_reglist_pick`: combinational; takes an NREG-bit mask and returns lowest-set index, `popcount`, and the mask with the lowest bit cleared.

## Test plan
- `0xE2821005` (ADD r1,r2,#5), `cond_pass = 1` -> one cycle later: `alu_sel = 4`, `read_rn = 2`, `write_rd = 1`, `rd_we = 1`, `imm = 5`, `shiftee_sel = IMMED_8_SEL`.
- `0xE1530004` (CMP r3,r4) -> `alu_sel = 0xA`, `rd_we = 0`, `cpsr_we = 1`, `read_rm = 4`, `barrel_sel = LSLIMM`.
- `0xEB000010` (BL) -> `imm = 0x40`, `read_rn = 15`, `pc_we = 1`, `link = 1`, `write_rd = 14`, `rd_we = 1`.
- `0xE8B0008A` (LDMIA r0!,{r1,r3,r7}) -> three uops: `write_rd` = 1, 3, 7 with `imm` = 0, 4, 8. Only the last uop has `rn_we = 1`, `wb_off = 12`. `inst_ready` is low for 2 cycles.
- Same LDM with `uop_ready` low for 3 cycles on the 2nd uop -> fields stay stable at `write_rd = 3` until it transfers. Repeat with `flush` asserted there -> `uop_valid = 0` and `inst_ready = 1` next cycle.
- `cond_pass = 0` on `0xE2821005` -> accepted, no `uop_valid` pulse. Reset asserted mid-LDM -> all outputs 0 immediately.
